sdram_pro_fifo_sched: RTL
=========================

Name: sdram_pro_fifo_sched

Overview:
- Burst scheduler between the write/read FIFOs and the SDRAM controller top.
- Watches FIFO fill levels and issues sdram_wr_req / sdram_rd_req with burst start addresses.
- Walks each address pointer through a configurable ring region and alternates fairly when both directions are eligible.
- Sits beside the FIFOs and drives the controller's wr/rd request, address and burst-length inputs.

Parameters:
ADDR_W, 23, SDRAM address width ({bank, row, col} packed exactly as the controller expects)
LEN_W, 10, burst length / FIFO level width
FIFO_DEPTH, 1024, read FIFO depth in words

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
init_end  in  1  SDRAM init complete; no request is issued before it is high
wr_fifo_usedw  in  LEN_W  words held in write FIFO
rd_fifo_usedw  in  LEN_W  words held in read FIFO
wr_burst_len  in  LEN_W  write burst length; sampled at grant
rd_burst_len  in  LEN_W  read burst length; sampled at grant
wr_addr_begin  in  ADDR_W  write region start
wr_addr_end  in  ADDR_W  write region end, exclusive
rd_addr_begin  in  ADDR_W  read region start
rd_addr_end  in  ADDR_W  read region end, exclusive
wr_addr_reload  in  1  pulse: reset write pointer to wr_addr_begin
rd_addr_reload  in  1  pulse: reset read pointer to rd_addr_begin
read_valid  in  1  read direction enable level
sdram_wr_ack  in  1  high while controller consumes write burst data
sdram_rd_ack  in  1  high while controller returns read burst data
sdram_wr_req  out  1  write burst request
sdram_rd_req  out  1  read burst request
sdram_wr_addr  out  ADDR_W  write burst start address
sdram_rd_addr  out  ADDR_W  read burst start address
sdram_wr_len  out  LEN_W  latched write burst length
sdram_rd_len  out  LEN_W  latched read burst length
sched_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; write and read pointers load their *_addr_begin values on the first clock after reset release; last_grant = read, so the first tie goes to write.
- Eligibility:
  - wr_elig = init_end && wr_burst_len != 0 && wr_fifo_usedw >= wr_burst_len.
  - rd_elig = init_end && read_valid && rd_burst_len != 0 && rd_fifo_usedw <= FIFO_DEPTH - rd_burst_len.
  - Compare in LEN_W+1 bits.
- States: IDLE, WR_REQ, WR_RUN, RD_REQ, RD_RUN.
- IDLE:
  - If only one direction is eligible, go to its *_REQ state.
  - If both are eligible, grant the opposite of last_grant.
  - At grant, latch the burst length into sdram_*_len and update last_grant.
  - One cycle from eligibility to req high.
- *_REQ:
  - req is high; address and len are held stable.
  - On the first cycle ack = 1: drop req the next cycle and go to *_RUN.
  - req stays high indefinitely until ack; there is no timeout.
- *_RUN:
  - Wait for ack = 0.
  - Then advance the pointer and return to IDLE.
  - Re-arbitration is possible on the following cycle.
- Pointer advance:
  - next = ptr + len, computed in ADDR_W+1 bits.
  - If next + len > end, ptr <= begin; else ptr <= next.
  - A burst never crosses end.
  - If begin + len > end, the pointer sticks at begin.
- Reload pulse:
  - In IDLE: applied the same cycle; it wins over any advance.
  - During that direction's REQ/RUN: held pending and applied in place of the advance at burst completion.
  - Both reload pulses may occur together; they are independent.
- Ack asserted in IDLE or for the non-granted direction is ignored; no state change.
- FIFO levels and read_valid are sampled only in IDLE; changes mid-burst have no effect.
- init_end falling:
  - No new grant.
  - An in-flight REQ keeps its req high until ack; the burst completes normally.
- Asynchronous reset mid-burst: req drops immediately and state goes to IDLE. The pointers do not hold their values: they take the reset value and load *_addr_begin on the first clock after release. The controller is reset by the same signal.

Test Plan:
- Write request and advance: init_end=1, wr_burst_len=256, wr_fifo_usedw 255→256. Required: sdram_wr_req high one cycle later with sdram_wr_addr=0 (begin 0, end 1024). Ack held 256 cycles. Required: next grant uses addr 256.
- Write-pointer wrap: begin 0, end 1000, len 256. Required: bursts at 0, 256, 512, then 0, because 768+256 > 1000.
- Simultaneous eligibility: wr_fifo_usedw=512, rd_fifo_usedw=0, read_valid=1, both lengths 128. Required grant order: W, R, W, R; no cycle where both reqs are high.
- Reload during burst: wr_addr_reload pulses during WR_RUN at addr 256. Required: next write addr = begin, not 384.
- Gating: read_valid=0, or rd_fifo_usedw=FIFO_DEPTH-rd_burst_len+1, or init_end=0, or burst_len=0. Required: no req ever; sched_busy=0.
- Reset mid-burst: sys_rst_n low during RD_REQ. Required: sdram_rd_req=0 asynchronously. After release: state IDLE, pointers at begin.

Source files
------------

// File: rtl/sdram_pro_fifo_sched.sv
// Burst scheduler: watches write/read FIFO levels and issues SDRAM burst requests,
// walking each address pointer around its own ring region with fair alternation.
module sdram_pro_fifo_sched #(
    parameter int ADDR_W     = 23,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic [LEN_W-1:0]  wr_fifo_usedw,
    input  logic [LEN_W-1:0]  rd_fifo_usedw,
    input  logic [LEN_W-1:0]  wr_burst_len,
    input  logic [LEN_W-1:0]  rd_burst_len,
    input  logic [ADDR_W-1:0] wr_addr_begin,
    input  logic [ADDR_W-1:0] wr_addr_end,
    input  logic [ADDR_W-1:0] rd_addr_begin,
    input  logic [ADDR_W-1:0] rd_addr_end,
    input  logic              wr_addr_reload,
    input  logic              rd_addr_reload,
    input  logic              read_valid,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [LEN_W-1:0]  sdram_wr_len,
    output logic [LEN_W-1:0]  sdram_rd_len,
    output logic              sched_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RUN = 3'd2,
        RD_REQ = 3'd3,
        RD_RUN = 3'd4
    } state_t;

    localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W+1)'(FIFO_DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic              loaded_reg;
    logic              wr_pend_reg, rd_pend_reg;
    logic              last_grant_rd_reg;

    logic wr_elig, rd_elig;
    logic wr_grant, rd_grant, wr_done, rd_done;
    logic wr_active, rd_active;
    logic [ADDR_W-1:0] wr_adv, rd_adv;

    // Next burst start; falls back to the region base when the following burst would cross the end.
    function automatic logic [ADDR_W-1:0] advance(
        input logic [ADDR_W-1:0] ptr,
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] limit
    );
        logic [ADDR_W+1:0] nxt;
        nxt = {2'b00, ptr} + (ADDR_W+2)'(len);
        if ((nxt + (ADDR_W+2)'(len)) > {2'b00, limit})
            return base;
        return nxt[ADDR_W-1:0];
    endfunction

    assign wr_elig = init_end && (wr_burst_len != '0) &&
                     ({1'b0, wr_fifo_usedw} >= {1'b0, wr_burst_len});
    assign rd_elig = init_end && read_valid && (rd_burst_len != '0) &&
                     ({1'b0, rd_fifo_usedw} <= (DEPTH_EXT - {1'b0, rd_burst_len}));

    assign wr_adv = advance(wr_ptr_reg, sdram_wr_len, wr_addr_begin, wr_addr_end);
    assign rd_adv = advance(rd_ptr_reg, sdram_rd_len, rd_addr_begin, rd_addr_end);

    assign wr_active    = (state_reg == WR_REQ) || (state_reg == WR_RUN);
    assign rd_active    = (state_reg == RD_REQ) || (state_reg == RD_RUN);
    assign sdram_wr_req = (state_reg == WR_REQ);
    assign sdram_rd_req = (state_reg == RD_REQ);
    assign sched_busy   = (state_reg != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        wr_grant   = 1'b0;
        rd_grant   = 1'b0;
        wr_done    = 1'b0;
        rd_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                // On a tie the direction not served last wins.
                if (wr_elig && (!rd_elig || last_grant_rd_reg)) begin
                    state_next = WR_REQ;
                    wr_grant   = 1'b1;
                end else if (rd_elig) begin
                    state_next = RD_REQ;
                    rd_grant   = 1'b1;
                end
            end
            WR_REQ: if (sdram_wr_ack) state_next = WR_RUN;
            WR_RUN: begin
                if (!sdram_wr_ack) begin
                    state_next = IDLE;
                    wr_done    = 1'b1;
                end
            end
            RD_REQ: if (sdram_rd_ack) state_next = RD_RUN;
            RD_RUN: begin
                if (!sdram_rd_ack) begin
                    state_next = IDLE;
                    rd_done    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            loaded_reg        <= 1'b0;
            wr_pend_reg       <= 1'b0;
            rd_pend_reg       <= 1'b0;
            last_grant_rd_reg <= 1'b1;
            sdram_wr_addr     <= '0;
            sdram_rd_addr     <= '0;
            sdram_wr_len      <= '0;
            sdram_rd_len      <= '0;
        end else begin
            loaded_reg <= 1'b1;

            if (!loaded_reg)
                wr_ptr_reg <= wr_addr_begin;
            else if (wr_done)
                wr_ptr_reg <= (wr_pend_reg || wr_addr_reload) ? wr_addr_begin : wr_adv;
            else if (wr_addr_reload && !wr_active)
                wr_ptr_reg <= wr_addr_begin;

            if (!loaded_reg || wr_done)
                wr_pend_reg <= 1'b0;
            else if (wr_addr_reload && wr_active)
                wr_pend_reg <= 1'b1;

            if (!loaded_reg)
                rd_ptr_reg <= rd_addr_begin;
            else if (rd_done)
                rd_ptr_reg <= (rd_pend_reg || rd_addr_reload) ? rd_addr_begin : rd_adv;
            else if (rd_addr_reload && !rd_active)
                rd_ptr_reg <= rd_addr_begin;

            if (!loaded_reg || rd_done)
                rd_pend_reg <= 1'b0;
            else if (rd_addr_reload && rd_active)
                rd_pend_reg <= 1'b1;

            // A reload seen in IDLE takes effect on the very grant it coincides with.
            if (wr_grant) begin
                sdram_wr_addr     <= (!loaded_reg || wr_addr_reload) ? wr_addr_begin : wr_ptr_reg;
                sdram_wr_len      <= wr_burst_len;
                last_grant_rd_reg <= 1'b0;
            end
            if (rd_grant) begin
                sdram_rd_addr     <= (!loaded_reg || rd_addr_reload) ? rd_addr_begin : rd_ptr_reg;
                sdram_rd_len      <= rd_burst_len;
                last_grant_rd_reg <= 1'b1;
            end
        end
    end

endmodule
